// File: rtl/decode_ibuf_if.sv
// decode_ibuf_if: fetch-side and issue-side handshake bundle for decode_ibuf.
//   master : driven by the environment (fetch, execute, redirect logic)
//   slave  : the instruction buffer itself
//   i_flush          redirect, discards queued and pending state
//   i_valid/o_ready  fetch handshake carrying i_pc/i_instr
//   o_valid/i_ready  issue handshake carrying head o_pc/o_instr
//   o_rs_no/o_rt_no/o_rd_no  register numbers decoded from the head
//   o_lu_stall       head held by a load-use hazard
//   o_level          queued entry count
interface decode_ibuf_if #(
    parameter int DEPTH_LOG2  = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   i_flush;
    logic                   i_valid;
    logic                   o_ready;
    logic [ADDR_WIDTH-1:0]  i_pc;
    logic [INSTR_WIDTH-1:0] i_instr;
    logic                   o_valid;
    logic                   i_ready;
    logic [ADDR_WIDTH-1:0]  o_pc;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic [4:0]             o_rs_no;
    logic [4:0]             o_rt_no;
    logic [4:0]             o_rd_no;
    logic                   o_lu_stall;
    logic [DEPTH_LOG2:0]    o_level;

    modport master (
        output i_flush, i_valid, i_pc, i_instr, i_ready,
        input  o_ready, o_valid, o_pc, o_instr, o_rs_no, o_rt_no, o_rd_no,
               o_lu_stall, o_level
    );
    modport slave (
        input  i_flush, i_valid, i_pc, i_instr, i_ready,
        output o_ready, o_valid, o_pc, o_instr, o_rs_no, o_rt_no, o_rd_no,
               o_lu_stall, o_level
    );
endinterface

// File: rtl/decode_ibuf.sv
// decode_ibuf: instruction queue between fetch and decode with first-word
// fall-through, register-number extraction from the head, and a load-use hold.
//   clk   core clock
//   nrst  asynchronous active-low reset
//   bus   decode_ibuf_if.slave (fetch handshake in, issue handshake out)
module decode_ibuf #(
    parameter int DEPTH_LOG2  = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int LU_CYCLES   = 1
) (
    input  logic          clk,
    input  logic          nrst,
    decode_ibuf_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [ADDR_WIDTH+INSTR_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  rd_ptr, wr_ptr;
    logic [DEPTH_LOG2:0]    level;
    logic                   empty, full, push, pop, valid, ready, stall, is_load;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic [INSTR_WIDTH-1:0] head_instr, instr;
    logic [5:0]             op, funct;
    logic [4:0]             rs_f, rt_f, rd_f, rs_no, rt_no, rd_no;
    logic                   lu_busy;
    logic [4:0]             lu_reg;
    logic [1:0]             lu_cnt;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);

    // Head reads as NOP while empty so decode never sees stale storage.
    assign {head_pc, head_instr} = mem[rd_ptr];
    assign instr = empty ? '0 : head_instr;
    assign op    = instr[31:26];
    assign rs_f  = instr[25:21];
    assign rt_f  = instr[20:16];
    assign rd_f  = instr[15:11];
    assign funct = instr[5:0];

    always_comb begin
        rs_no = rs_f;
        rt_no = rt_f;
        rd_no = rd_f;
        case (op)
            6'h00: begin
                if (funct == 6'h08 || funct == 6'h09) rt_no = '0;
                case (funct)
                    6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: rd_no = '0;
                    default: rd_no = rd_f;
                endcase
            end
            6'h01: rd_no = (rt_f == 5'h10 || rt_f == 5'h11) ? 5'd31 : 5'd0;
            6'h02: begin rs_no = '0; rd_no = '0; end
            6'h03: begin rs_no = '0; rd_no = 5'd31; end
            6'h04, 6'h05, 6'h06, 6'h07: rd_no = '0;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: rd_no = rt_f;
            6'h0f: begin rs_no = '0; rd_no = rt_f; end
            6'h10: rs_no = '0;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: rd_no = rt_f;
            6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2c, 6'h2d, 6'h2e: rd_no = '0;
            default: rd_no = rd_f;
        endcase
    end

    assign is_load = (op >= 6'h20) && (op <= 6'h25);
    assign stall   = !empty && lu_busy && (lu_reg != '0) &&
                     (rs_no == lu_reg || rt_no == lu_reg);
    assign valid   = !empty && !stall;
    // Full queue still accepts when the head leaves in the same cycle.
    assign ready   = !full || (valid && bus.i_ready);
    // A redirect cancels both handshakes of its cycle.
    assign push    = bus.i_valid && ready && !bus.i_flush;
    assign pop     = valid && bus.i_ready && !bus.i_flush;

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid;
    assign bus.o_pc       = empty ? '0 : head_pc;
    assign bus.o_instr    = instr;
    assign bus.o_rs_no    = rs_no;
    assign bus.o_rt_no    = rt_no;
    assign bus.o_rd_no    = rd_no;
    assign bus.o_lu_stall = stall;
    assign bus.o_level    = level;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.i_pc, bus.i_instr};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            lu_busy <= 1'b0;
            lu_reg  <= '0;
            lu_cnt  <= '0;
        end else if (bus.i_flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            lu_busy <= 1'b0;
            lu_reg  <= '0;
            lu_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Issued load with a real destination opens the busy window;
            // otherwise the window counts down and closes at zero.
            if (pop && is_load && rd_no != '0) begin
                lu_busy <= 1'b1;
                lu_reg  <= rd_no;
                lu_cnt  <= 2'(LU_CYCLES);
            end else if (lu_busy) begin
                lu_cnt <= lu_cnt - 1'b1;
                if (lu_cnt == 2'd1) lu_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_ibuf.sv
module tb_decode_ibuf;
    localparam int DL = 2;
    localparam int AW = 32;
    localparam int IW = 32;

    localparam logic [31:0] LW_R5   = 32'h8C050000;
    localparam logic [31:0] LW_R0   = 32'h8C000000;
    localparam logic [31:0] ADDU_R5 = 32'h00A53021;
    localparam logic [31:0] ADDU_R0 = 32'h00003021;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    decode_ibuf_if #(.DEPTH_LOG2(DL), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    decode_ibuf #(.DEPTH_LOG2(DL), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .LU_CYCLES(1)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  rs, rt, rd;
        string       tag;
    } dec_t;
    dec_t dtab[5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl = 1'b0);
        bus.i_valid = v;
        bus.i_pc    = pc;
        bus.i_instr = ins;
        bus.i_ready = rdy;
        bus.i_flush = fl;
    endtask

    // Observe the handshakes mid-cycle: pushes feed the scoreboard, pops are checked.
    task automatic sample();
        logic [63:0] e;
        @(negedge clk);
        if (nrst && bus.i_flush) begin
            sb.delete();
        end else if (nrst) begin
            if (bus.i_valid && bus.o_ready) sb.push_back({bus.i_pc, bus.i_instr});
            if (bus.o_valid && bus.i_ready) begin
                chk("pop_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pop_pc", 64'(bus.o_pc), 64'(e[63:32]));
                    chk("pop_instr", 64'(bus.o_instr), 64'(e[31:0]));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    initial begin
        dtab[0] = '{32'h0C000010, 5'd0, 5'd0,  5'd31, "jal"};
        dtab[1] = '{32'h34231234, 5'd1, 5'd3,  5'd3,  "ori"};
        dtab[2] = '{32'hAC220000, 5'd1, 5'd2,  5'd0,  "sw"};
        dtab[3] = '{32'h00E00008, 5'd7, 5'd0,  5'd0,  "jr"};
        dtab[4] = '{32'h04910000, 5'd4, 5'd17, 5'd31, "bgezal"};

        // Reset state
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_level", 64'(bus.o_level), 64'd0);
        chk("rst_stall", 64'(bus.o_lu_stall), 64'd0);
        chk("rst_pc", 64'(bus.o_pc), 64'd0);
        chk("rst_instr", 64'(bus.o_instr), 64'd0);
        nrst = 1'b1;

        // Fill with five words while execute is blocked
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 32'h24000000 + 32'(k), 1'b0);
            sample();
            if (k == 0) chk("fwft_no_bypass", 64'(bus.o_valid), 64'd0);
            if (k == 1) chk("fwft_next", 64'(bus.o_valid), 64'd1);
            if (k == 4) begin
                chk("fill_level", 64'(bus.o_level), 64'd4);
                chk("fill_ready", 64'(bus.o_ready), 64'd0);
            end
            tick();
        end

        // Full with simultaneous push and pop; fifth word goes in first
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 32'h100 + 32'(4 * (4 + j)), 32'h24000000 + 32'(4 + j), 1'b1);
            sample();
            chk("full_sim_ready", 64'(bus.o_ready), 64'd1);
            chk("full_sim_level", 64'(bus.o_level), 64'd4);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (4) step();
        sample();
        chk("drain_level", 64'(bus.o_level), 64'd0);
        chk("drain_valid", 64'(bus.o_valid), 64'd0);
        tick();

        // Load-use hazard
        drive(1'b1, 32'h200, LW_R5, 1'b0);   step();
        drive(1'b1, 32'h204, ADDU_R5, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        sample();
        chk("lw_issue_valid", 64'(bus.o_valid), 64'd1);
        tick();
        sample();
        chk("lu_stall_on", 64'(bus.o_lu_stall), 64'd1);
        chk("lu_valid_off", 64'(bus.o_valid), 64'd0);
        tick();
        sample();
        chk("lu_stall_off", 64'(bus.o_lu_stall), 64'd0);
        chk("lu_valid_on", 64'(bus.o_valid), 64'd1);
        tick();

        drive(1'b1, 32'h208, LW_R0, 1'b0);   step();
        drive(1'b1, 32'h20C, ADDU_R0, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        sample();
        chk("lw_r0_stall", 64'(bus.o_lu_stall), 64'd0);
        chk("lw_r0_valid", 64'(bus.o_valid), 64'd1);
        tick();

        // Register-number decode of the head
        for (int d = 0; d < 5; d++) begin
            drive(1'b1, 32'h280 + 32'(4 * d), dtab[d].ins, 1'b0);
            step();
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            sample();
            chk({"dec_rs_", dtab[d].tag}, 64'(bus.o_rs_no), 64'(dtab[d].rs));
            chk({"dec_rt_", dtab[d].tag}, 64'(bus.o_rt_no), 64'(dtab[d].rt));
            chk({"dec_rd_", dtab[d].tag}, 64'(bus.o_rd_no), 64'(dtab[d].rd));
            tick();
        end

        // Flush with three queued words and a load in flight
        drive(1'b1, 32'h300, LW_R5, 1'b0);      step();
        drive(1'b1, 32'h304, ADDU_R5, 1'b0);    step();
        drive(1'b1, 32'h308, 32'h24000008, 1'b0); step();
        drive(1'b1, 32'h30C, 32'h2400000C, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        drive(1'b1, 32'h310, 32'h24000077, 1'b1, 1'b1);
        sample();
        chk("flush_pre_level", 64'(bus.o_level), 64'd3);
        chk("flush_pre_stall", 64'(bus.o_lu_stall), 64'd1);
        chk("flush_pre_ready", 64'(bus.o_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        sample();
        chk("flush_level", 64'(bus.o_level), 64'd0);
        chk("flush_valid", 64'(bus.o_valid), 64'd0);
        tick();
        drive(1'b1, 32'h320, ADDU_R5, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        sample();
        chk("post_flush_stall", 64'(bus.o_lu_stall), 64'd0);
        chk("post_flush_valid", 64'(bus.o_valid), 64'd1);
        chk("post_flush_level", 64'(bus.o_level), 64'd1);
        chk("post_flush_instr", 64'(bus.o_instr), 64'(ADDU_R5));
        tick();

        // Reset asserted mid-stream
        drive(1'b1, 32'h400, 32'h24000040, 1'b0); step();
        drive(1'b1, 32'h404, 32'h24000044, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_level", 64'(bus.o_level), 64'd0);
        sb.delete();
        tick();
        nrst = 1'b1;
        drive(1'b1, 32'h408, 32'h24000048, 1'b1);
        sample();
        chk("rel_no_bypass", 64'(bus.o_valid), 64'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        sample();
        chk("rel_valid", 64'(bus.o_valid), 64'd1);
        tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
